// File: rtl/pwm_fade_pkg.sv
// Shared constants for the PWM fade bank: channel modes and fade direction encodings.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pwm_fade_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_TRI  = 2'b00;  // triangle sweep 0..LMAX..0
    localparam mode_t MODE_SAW  = 2'b01;  // ramp up, wrap LMAX->0
    localparam mode_t MODE_HOLD = 2'b10;  // freeze level, divider keeps running
    localparam mode_t MODE_OFF  = 2'b11;  // force level/dir/divider to idle

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/pwm_fade_channel.sv
// One fade channel: step divider, level/dir FSM, optional gamma, duty shadow and PWM compare.
// Latency: o_led is registered, 1 clock behind pwm_cnt; level changes reach the duty at the next period boundary.
// Backpressure: none; en=0 freezes all state and forces led low.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en              global enable
//   speed           clocks per level step (0 = frozen)
//   mode            channel mode (see pwm_fade_pkg)
//   pwm_cnt         shared free-running PWM counter
//   pwm_last        pwm_cnt is at LMAX this clock (period boundary)
//   led             registered PWM output
//   level           current linear fade level
// Build option: PWM_FADE_GAMMA_EN selects a squared (gamma ~2) duty curve.
module fade_channel
    import pwm_fade_pkg::*;
#(
    parameter int PWM_W = 8,
    parameter int SPD_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [SPD_W-1:0] speed,
    input  mode_t            mode,
    input  logic [PWM_W-1:0] pwm_cnt,
    input  logic             pwm_last,
    output logic             led,
    output logic [PWM_W-1:0] level
);

    localparam logic [PWM_W-1:0] LMAX    = '1;
    localparam logic [PWM_W-1:0] LMAX_M1 = LMAX - 1'b1;
    localparam logic [PWM_W-1:0] ONE     = {{(PWM_W-1){1'b0}}, 1'b1};

    logic [SPD_W-1:0] div_cnt;
    logic [SPD_W-1:0] div_nxt;
    logic             dir;
    logic             dir_nxt;
    logic [PWM_W-1:0] level_nxt;
    logic [PWM_W-1:0] duty_sh;
    logic [PWM_W-1:0] duty_nxt;
    logic [SPD_W:0]   speed_m1;
    logic             step;

    // One extra bit so speed==0 yields all-ones rather than wrapping to a small value.
    assign speed_m1 = {1'b0, speed} - {{SPD_W{1'b0}}, 1'b1};
    // '>=' so a speed decrease below the current count steps at once instead of stalling.
    assign step     = (speed != '0) && ({1'b0, div_cnt} >= speed_m1);

`ifdef PWM_FADE_GAMMA_EN
    logic [2*PWM_W-1:0] level_sq;
    assign level_sq = {{PWM_W{1'b0}}, level} * {{PWM_W{1'b0}}, level};
    assign duty_nxt = level_sq[2*PWM_W-1:PWM_W];
`else
    assign duty_nxt = level;
`endif

    always_comb begin
        div_nxt   = div_cnt + 1'b1;
        level_nxt = level;
        dir_nxt   = dir;
        if ((mode == MODE_OFF) || (speed == '0) || step) begin
            div_nxt = '0;
        end
        case (mode)
            MODE_TRI: begin
                if (step) begin
                    if (dir == DIR_UP) begin
                        // Guard for entering tri at LMAX with dir up (e.g. from saw/hold).
                        if (level == LMAX) begin
                            level_nxt = LMAX_M1;
                            dir_nxt   = DIR_DOWN;
                        end else begin
                            level_nxt = level + 1'b1;
                            if (level == LMAX_M1) dir_nxt = DIR_DOWN;
                        end
                    end else begin
                        if (level == '0) begin
                            level_nxt = ONE;
                            dir_nxt   = DIR_UP;
                        end else begin
                            level_nxt = level - 1'b1;
                            if (level == ONE) dir_nxt = DIR_UP;
                        end
                    end
                end
            end
            MODE_SAW: begin
                dir_nxt = DIR_UP;
                if (step) level_nxt = level + 1'b1;
            end
            MODE_HOLD: begin
                level_nxt = level;
            end
            default: begin
                level_nxt = '0;
                dir_nxt   = DIR_UP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            level   <= '0;
            dir     <= DIR_UP;
            duty_sh <= '0;
            led     <= 1'b0;
        end else if (en) begin
            div_cnt <= div_nxt;
            level   <= level_nxt;
            dir     <= dir_nxt;
            // Shadow only reloads at the period boundary so a period never glitches.
            if (pwm_last) duty_sh <= duty_nxt;
            led     <= (pwm_cnt < duty_sh);
        end else begin
            led     <= 1'b0;
        end
    end

endmodule

// File: rtl/pwm_fade_bank.sv
// N-channel smooth-fade PWM bank sharing one free-running PWM counter.
// Latency: o_led 1 clock after pwm_cnt; o_period_tick 1 clock after pwm_cnt==LMAX.
// Backpressure: none; i_en=0 freezes every counter and forces o_led low.
//
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_en            global enable
//   i_speed         per-channel speed words, ch c = [c*SPD_W +: SPD_W]
//   i_mode          per-channel mode, ch c = [2c +: 2]
//   o_led           registered PWM outputs
//   o_level         per-channel linear fade level, ch c = [c*PWM_W +: PWM_W]
//   o_period_tick   1-cycle pulse when pwm_cnt wraps LMAX->0
// Build option: PWM_FADE_GAMMA_EN enables squared duty curve in each channel.
module pwm_fade_bank
    import pwm_fade_pkg::*;
#(
    parameter int N_CH  = 3,
    parameter int PWM_W = 8,
    parameter int SPD_W = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic [N_CH*SPD_W-1:0]   i_speed,
    input  logic [2*N_CH-1:0]       i_mode,
    output logic [N_CH-1:0]         o_led,
    output logic [N_CH*PWM_W-1:0]   o_level,
    output logic                    o_period_tick
);

    localparam logic [PWM_W-1:0] LMAX = '1;

    logic [PWM_W-1:0] pwm_cnt;
    logic             pwm_last;

    assign pwm_last = (pwm_cnt == LMAX);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pwm_cnt       <= '0;
            o_period_tick <= 1'b0;
        end else begin
            if (i_en) pwm_cnt <= pwm_cnt + 1'b1;
            o_period_tick <= pwm_last & i_en;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        fade_channel #(
            .PWM_W (PWM_W),
            .SPD_W (SPD_W)
        ) u_ch (
            .clk      (i_clk),
            .rst      (i_rst),
            .en       (i_en),
            .speed    (i_speed[c*SPD_W +: SPD_W]),
            .mode     (i_mode[2*c +: 2]),
            .pwm_cnt  (pwm_cnt),
            .pwm_last (pwm_last),
            .led      (o_led[c]),
            .level    (o_level[c*PWM_W +: PWM_W])
        );
    end

endmodule

// File: tb/tb_pwm_fade_bank.sv
// Directed bench for pwm_fade_bank: a 4-bit 3-channel instance and an 8-bit 2-channel instance.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_pwm_fade_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-bit PWM instance
    logic        rst4, en4;
    logic [47:0] speed4;
    logic [5:0]  mode4;
    logic [2:0]  led4;
    logic [11:0] level4;
    logic        tick4;

    // 8-bit PWM instance
    logic        rst8, en8;
    logic [31:0] speed8;
    logic [3:0]  mode8;
    logic [1:0]  led8;
    logic [15:0] level8;
    logic        tick8;

    pwm_fade_bank #(.N_CH(3), .PWM_W(4), .SPD_W(16)) dut4 (
        .i_clk(clk), .i_rst(rst4), .i_en(en4), .i_speed(speed4), .i_mode(mode4),
        .o_led(led4), .o_level(level4), .o_period_tick(tick4)
    );

    pwm_fade_bank #(.N_CH(2), .PWM_W(8), .SPD_W(16)) dut8 (
        .i_clk(clk), .i_rst(rst8), .i_en(en8), .i_speed(speed8), .i_mode(mode8),
        .o_led(led8), .o_level(level8), .o_period_tick(tick8)
    );

    int checks   = 0;
    int failures = 0;

    int t4;
    int m_pwm;
    int m_duty [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Triangle at speed 2: one step per 2 clocks, 30 steps per full sweep.
    function automatic int tri_lvl(input int t);
        int s, p;
        s = t / 2;
        p = s % 30;
        return (p <= 15) ? p : 30 - p;
    endfunction

    function automatic int exp4(input int c, input int t);
        if (c == 0) return tri_lvl(t);
        if (c == 1) return t % 16;
        return 0;
    endfunction

    function automatic int f4(input int l);
`ifdef PWM_FADE_GAMMA_EN
        return (l * l) >> 4;
`else
        return l;
`endif
    endfunction

    function automatic int f8(input int l);
`ifdef PWM_FADE_GAMMA_EN
        return (l * l) >> 8;
`else
        return l;
`endif
    endfunction

    // One clock of dut4 against the expected level sequences and a period-shadow duty model.
    task automatic step4();
        int lp [3];
        for (int c = 0; c < 3; c++) lp[c] = exp4(c, t4);
        tick();
        t4++;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("lvl4_ch%0d_t%0d", c, t4), 32'(level4[c*4 +: 4]), 32'(exp4(c, t4)));
            check($sformatf("led4_ch%0d_t%0d", c, t4), 32'(led4[c]), 32'(m_pwm < m_duty[c]));
        end
        check($sformatf("tick4_t%0d", t4), 32'(tick4), 32'(m_pwm == 15));
        if (m_pwm == 15) begin
            for (int c = 0; c < 3; c++) m_duty[c] = f4(lp[c]);
        end
        m_pwm = (m_pwm + 1) % 16;
    endtask

    task automatic restart4();
        t4    = 0;
        m_pwm = 0;
        for (int c = 0; c < 3; c++) m_duty[c] = 0;
    endtask

    // Count ch0 highs over one full period once the shadow has settled.
    task automatic measure_duty8(input string tag, input int exp);
        int hi;
        repeat (300) tick();
        hi = 0;
        repeat (256) begin
            tick();
            hi = hi + int'(led8[0]);
        end
        check(tag, 32'(hi), 32'(exp));
    endtask

    initial begin
        int hi, hi1, lo_at, found, seen;

        rst4   = 1'b1;
        rst8   = 1'b1;
        en4    = 1'b1;
        en8    = 1'b1;
        speed4 = {16'd3, 16'd1, 16'd2};
        mode4  = {2'b10, 2'b01, 2'b00};   // ch2 hold, ch1 saw, ch0 tri
        speed8 = {16'd5, 16'd1};
        mode8  = {2'b11, 2'b01};          // ch1 off, ch0 saw
        restart4();

        repeat (2) tick();
        check("rst4_level", 32'(level4), 32'd0);
        check("rst4_led",   32'(led4),   32'd0);
        check("rst4_tick",  32'(tick4),  32'd0);

        // Triangle / saw / hold sweep with PWM output model
        rst4 = 1'b0;
        repeat (100) step4();

        // Reset mid-sweep while the triangle is heading down
        rst4 = 1'b1;
        tick();
        check("rst4_mid_level", 32'(level4), 32'd0);
        check("rst4_mid_led",   32'(led4),   32'd0);
        check("rst4_mid_tick",  32'(tick4),  32'd0);
        repeat (2) tick();
        check("rst4_hold_level", 32'(level4), 32'd0);
        check("rst4_hold_led",   32'(led4),   32'd0);
        rst4 = 1'b0;
        restart4();
        repeat (4) step4();   // tri must climb again, proving dir returned to up

        // 8-bit instance: saw to LMAX, then hold for full-duty measurement
        rst8 = 1'b0;
        repeat (255) tick();
        check("lvl8_saw_255", 32'(level8[7:0]),  32'd255);
        check("lvl8_off_ch1", 32'(level8[15:8]), 32'd0);
        mode8[1:0] = 2'b10;
        tick();
        check("lvl8_hold_255", 32'(level8[7:0]), 32'd255);

        hi = 0; hi1 = 0; lo_at = -1;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (led8[0]) hi++;
            else lo_at = i;
            hi1 = hi1 + int'(led8[1]);
        end
        check("led8_full_highs", 32'(hi),    32'(f8(255)));
        check("led8_full_lowpos", 32'(lo_at), 32'd255);
        check("led8_zero_highs", 32'(hi1),   32'd0);

        // Speed drop mid-count steps immediately
        speed8[15:0] = 16'd1000;
        mode8[1:0]   = 2'b01;
        repeat (900) tick();
        check("spd_no_step_900", 32'(level8[7:0]), 32'd255);
        speed8[15:0] = 16'd10;
        tick();
        check("spd_drop_step", 32'(level8[7:0]), 32'd0);
        repeat (9) tick();
        check("spd10_wait", 32'(level8[7:0]), 32'd0);
        tick();
        check("spd10_step", 32'(level8[7:0]), 32'd1);

        // Speed zero freezes the level
        speed8[15:0] = 16'd0;
        repeat (20) tick();
        check("spd0_frozen", 32'(level8[7:0]), 32'd1);

        // Hold at 37 and measure its duty
        speed8[15:0] = 16'd1;
        repeat (36) tick();
        check("saw_to_37", 32'(level8[7:0]), 32'd37);
        mode8[1:0] = 2'b10;
        repeat (10) tick();
        check("hold_37", 32'(level8[7:0]), 32'd37);
        measure_duty8("duty_37", f8(37));

        // Level 128 duty (64 with gamma)
        mode8[1:0] = 2'b01;
        repeat (91) tick();
        check("saw_to_128", 32'(level8[7:0]), 32'd128);
        mode8[1:0] = 2'b10;
        measure_duty8("duty_128", f8(128));

        // Enable freeze and exact resume of pwm_cnt
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            tick();
            if (tick8) found = 1;
        end
        check("tick8_seen", 32'(found), 32'd1);
        repeat (100) tick();
        en8 = 1'b0;
        tick();
        check("en0_led",  32'(led8),  32'd0);
        check("en0_tick", 32'(tick8), 32'd0);
        hi = 0;
        repeat (19) begin
            tick();
            hi = hi + int'(led8[0]) + int'(tick8);
        end
        check("en0_quiet", 32'(hi), 32'd0);
        check("en0_level", 32'(level8[7:0]), 32'd128);
        en8  = 1'b1;
        seen = 0;
        repeat (155) begin
            tick();
            seen = seen + int'(tick8);
        end
        check("resume_no_early_tick", 32'(seen), 32'd0);
        tick();
        check("resume_tick_exact", 32'(tick8), 32'd1);

        // Off clears level; divider held across a disable
        mode8[1:0] = 2'b11;
        tick();
        check("off_level0", 32'(level8[7:0]), 32'd0);
        mode8[1:0]   = 2'b01;
        speed8[15:0] = 16'd3;
        repeat (4) tick();
        check("saw3_lvl1", 32'(level8[7:0]), 32'd1);
        en8 = 1'b0;
        repeat (20) tick();
        check("saw3_frozen", 32'(level8[7:0]), 32'd1);
        en8 = 1'b1;
        tick();
        check("saw3_resume_a", 32'(level8[7:0]), 32'd1);
        tick();
        check("saw3_resume_b", 32'(level8[7:0]), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
